pipeline_hazard_sequencer: RTL and testbench

PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

---
 rtl/pipeline_hazard_sequencer.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_sequencer.sv
// Forwarding selects, load-use stall and redirect flush sequencing for a 5-stage pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  idex_rt,
    input  logic        idex_memread,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_regwrite,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ctrl_pass,
    output logic        if_flush,
    output logic        branch_sel,
    output logic        jump_sel,
    output logic        jr_sel,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t state, state_next;
    logic   hz;
    logic   rd;

    // EX/MEM result is newer than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src))
            return 2'd1;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign fwd_a = fwd_sel(ex_rs);
    assign fwd_b = fwd_sel(ex_rt);

    assign hz = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == id_rs) || (idex_rt == id_rt));
    assign rd = branch_taken | jump | jr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = RUN;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ctrl_pass  = 1'b1;
        if_flush   = 1'b0;
        branch_sel = 1'b0;
        jump_sel   = 1'b0;
        jr_sel     = 1'b0;
        case (state)
            RUN, STALL: begin
                if (rd) begin
                    branch_sel = branch_taken;
                    jump_sel   = jump;
                    jr_sel     = jr;
                    if_flush   = 1'b1;
                    state_next = FLUSH;
                end else if (hz && (state == RUN)) begin
                    // A hazard seen again in STALL is the same load, already covered.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    ctrl_pass  = 1'b0;
                    state_next = STALL;
                end
            end
            FLUSH: begin
                // Redirect requests here come from the squashed instruction.
                if_flush   = 1'b1;
                ctrl_pass  = 1'b0;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if ((state == RUN) && (state_next == STALL) && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
            if ((state_next == FLUSH) && (flush_q != 16'hFFFF))
                flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed self-checking bench for pipeline_hazard_sequencer (both counter builds).
module tb_pipeline_hazard_sequencer;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, idex_rt, ex_rs, ex_rt, exmem_rd, memwb_rd;
    logic        idex_memread, exmem_regwrite, memwb_regwrite;
    logic        branch_taken, jump, jr;
    logic [1:0]  fwd_a, fwd_b;
    logic        pc_write, ifid_write, ctrl_pass, if_flush;
    logic        branch_sel, jump_sel, jr_sel;
    logic [15:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    pipeline_hazard_sequencer dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .idex_rt(idex_rt), .idex_memread(idex_memread),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .branch_taken(branch_taken), .jump(jump), .jr(jr),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ctrl_pass(ctrl_pass), .if_flush(if_flush),
        .branch_sel(branch_sel), .jump_sel(jump_sel), .jr_sel(jr_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt(input logic [15:0] n);
        return CNT_EN ? n : 16'd0;
    endfunction

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; idex_rt = 0; idex_memread = 0;
        ex_rs = 0; ex_rt = 0; exmem_rd = 0; exmem_regwrite = 0;
        memwb_rd = 0; memwb_regwrite = 0;
        branch_taken = 0; jump = 0; jr = 0;
    endtask

    task automatic set_hz();
        idex_memread = 1; idex_rt = 8; id_rs = 8;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_ctrl_pass", ctrl_pass, 1);
        chk("rst_if_flush", if_flush, 0);
        chk("rst_sels", {branch_sel, jump_sel, jr_sel}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        reset = 1'b0;

        // Forwarding
        @(negedge clk);
        ex_rs = 5; exmem_rd = 5; exmem_regwrite = 1; memwb_rd = 5; memwb_regwrite = 1;
        #1 chk("fwd_a_exmem", fwd_a, 1);
        exmem_regwrite = 0;
        #1 chk("fwd_a_memwb", fwd_a, 2);
        ex_rs = 0;
        #1 chk("fwd_a_r0", fwd_a, 0);
        ex_rt = 7; exmem_rd = 7; exmem_regwrite = 1; memwb_rd = 7; memwb_regwrite = 1;
        #1 chk("fwd_b_exmem", fwd_b, 1);
        exmem_rd = 3;
        #1 chk("fwd_b_memwb", fwd_b, 2);
        memwb_regwrite = 0;
        #1 chk("fwd_b_none", fwd_b, 0);
        clear_inputs();

        // Load-use: two cycles of hazard give exactly one stall
        @(negedge clk);
        set_hz();
        #1;
        chk("lu_c1_pc_write", pc_write, 0);
        chk("lu_c1_ifid_write", ifid_write, 0);
        chk("lu_c1_ctrl_pass", ctrl_pass, 0);
        @(negedge clk);
        #1;
        chk("lu_c2_pc_write", pc_write, 1);
        chk("lu_c2_ctrl_pass", ctrl_pass, 1);
        chk("lu_stall_cnt1", stall_cnt, cnt(1));
        @(negedge clk);
        #1 chk("lu_back_in_run", pc_write, 0);
        @(negedge clk);
        clear_inputs();
        #1 chk("lu_stall_cnt2", stall_cnt, cnt(2));

        // Jump redirect, then flush cycle ignores a branch
        @(negedge clk);
        jump = 1;
        #1;
        chk("j_jump_sel", jump_sel, 1);
        chk("j_if_flush", if_flush, 1);
        chk("j_pc_write", pc_write, 1);
        chk("j_ctrl_pass", ctrl_pass, 1);
        @(negedge clk);
        jump = 0; branch_taken = 1;
        #1;
        chk("fl_if_flush", if_flush, 1);
        chk("fl_ctrl_pass", ctrl_pass, 0);
        chk("fl_sels", {branch_sel, jump_sel, jr_sel}, 0);
        chk("fl_pc_write", pc_write, 1);
        chk("fl_flush_cnt1", flush_cnt, cnt(1));

        // Simultaneous hazard and branch: redirect wins
        @(negedge clk);
        set_hz(); branch_taken = 1;
        #1;
        chk("sim_branch_sel", branch_sel, 1);
        chk("sim_pc_write", pc_write, 1);
        chk("sim_ctrl_pass", ctrl_pass, 1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("sim_next_flush", if_flush, 1);
        chk("sim_stall_cnt", stall_cnt, cnt(2));
        chk("sim_flush_cnt", flush_cnt, cnt(2));

        // Redirect honoured while stalled
        @(negedge clk);
        set_hz();
        #1 chk("st_enter", pc_write, 0);
        @(negedge clk);
        jr = 1;
        #1;
        chk("st_jr_sel", jr_sel, 1);
        chk("st_if_flush", if_flush, 1);
        chk("st_pc_write", pc_write, 1);
        chk("st_stall_cnt", stall_cnt, cnt(3));
        @(negedge clk);
        clear_inputs();
        #1;
        chk("st_flush", ctrl_pass, 0);
        chk("st_flush_cnt", flush_cnt, cnt(3));

        // Asynchronous reset mid-FLUSH
        #2 reset = 1'b1;
        #1;
        chk("arst_if_flush", if_flush, 0);
        chk("arst_ctrl_pass", ctrl_pass, 1);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        set_hz();
        #1 chk("arst_run_after", pc_write, 0);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);

        // Saturation of the stall counter
`ifdef HAZARD_PERF_CNT_EN
        dut.stall_q = 16'hFFFF;
`endif
        set_hz();
        @(negedge clk);
        clear_inputs();
        #1 chk("sat_stall_cnt", stall_cnt, cnt(16'hFFFF));
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
